// File: rtl/rv32_mc_core.sv
// Multi-cycle RV32I/RV32E-subset core: a FETCH/DECODE/EXEC/MEM/WB FSM on one shared req/ack memory port.
// Define RV_BRANCH_EN to add BEQ, BNE and JAL; without it those opcodes trap like any other illegal word.
module rv32_mc_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32,
  parameter int          XW       = 32
) (
  input  logic          CLK,
  input  logic          RST,
  output logic          mem_req,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [XW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [XW-1:0] mem_rdata,
  output logic [31:0]   pc,
  output logic [31:0]   instr,
  output logic [2:0]    state,
  output logic          retire,
  output logic          trap
);

  if (NREGS != 32 && NREGS != 16) begin : g_bad_nregs
    $error("rv32_mc_core: NREGS must be 32 (RV32I) or 16 (RV32E)");
  end
  if (XW != 32) begin : g_bad_xw
    $error("rv32_mc_core: XW must be 32");
  end

  localparam int RW = (NREGS == 16) ? 4 : 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
`ifdef RV_BRANCH_EN
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
`endif

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_LW, K_SW, K_LUI, K_BEQ, K_BNE, K_JAL
  } kind_e;

  state_e        state_q, state_d;
  kind_e         kind_q, kind_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic          use_imm_q, use_imm_d;
  logic [XW-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, r_q, r_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [XW-1:0] mem_wdata_q, mem_wdata_d;
  logic          retire_c;
  logic          gpr_we;
  logic [XW-1:0] gpr_q [NREGS];
`ifdef RV_BRANCH_EN
  logic [31:0]   tgt_q, tgt_d;
  logic [31:0]   br_tgt;
  logic          br_taken;
`endif

  // Instruction fields and immediates
  logic [6:0]    opcode, funct7;
  logic [2:0]    funct3;
  logic [4:0]    rs1_idx, rs2_idx, rd_idx;
  logic [XW-1:0] imm_i, imm_s, imm_u;

  assign opcode  = instr_q[6:0];
  assign rd_idx  = instr_q[11:7];
  assign funct3  = instr_q[14:12];
  assign rs1_idx = instr_q[19:15];
  assign rs2_idx = instr_q[24:20];
  assign funct7  = instr_q[31:25];
  assign imm_i   = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s   = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_u   = {instr_q[31:12], 12'h000};
`ifdef RV_BRANCH_EN
  logic [XW-1:0] imm_b, imm_j;
  assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
`endif

  kind_e         dec_kind;
  logic [XW-1:0] dec_imm;
  logic          dec_use_imm, dec_legal, use_rs1, use_rs2, use_rd, bad_idx;

  // NOTE: every always_comb output gets a default before the case; a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    dec_kind    = K_ADD;
    dec_imm     = '0;
    dec_use_imm = 1'b0;
    dec_legal   = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    use_rd      = 1'b0;
    case (opcode)
      OPC_OP: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        use_rd    = 1'b1;
        dec_legal = 1'b1;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: dec_kind = K_ADD;
          {7'b0100000, 3'b000}: dec_kind = K_SUB;
          {7'b0000000, 3'b111}: dec_kind = K_AND;
          {7'b0000000, 3'b110}: dec_kind = K_OR;
          {7'b0000000, 3'b010}: dec_kind = K_SLT;
          default:              dec_legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        use_rs1     = 1'b1;
        use_rd      = 1'b1;
        dec_use_imm = 1'b1;
        dec_imm     = imm_i;
        dec_legal   = 1'b1;
        case (funct3)
          3'b000:  dec_kind = K_ADD;
          3'b111:  dec_kind = K_AND;
          3'b110:  dec_kind = K_OR;
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        use_rs1     = 1'b1;
        use_rd      = 1'b1;
        dec_use_imm = 1'b1;
        dec_imm     = imm_i;
        dec_kind    = K_LW;
        dec_legal   = (funct3 == 3'b010);
      end
      OPC_STORE: begin
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        dec_use_imm = 1'b1;
        dec_imm     = imm_s;
        dec_kind    = K_SW;
        dec_legal   = (funct3 == 3'b010);
      end
      OPC_LUI: begin
        use_rd    = 1'b1;
        dec_imm   = imm_u;
        dec_kind  = K_LUI;
        dec_legal = 1'b1;
      end
`ifdef RV_BRANCH_EN
      OPC_BRANCH: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        dec_imm   = imm_b;
        dec_legal = 1'b1;
        case (funct3)
          3'b000:  dec_kind = K_BEQ;
          3'b001:  dec_kind = K_BNE;
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_JAL: begin
        use_rd    = 1'b1;
        dec_imm   = imm_j;
        dec_kind  = K_JAL;
        dec_legal = 1'b1;
      end
`endif
      default: dec_legal = 1'b0;
    endcase
  end

  // RV32E only has x0..x15, so any referenced index with bit 4 set is illegal
  assign bad_idx = (NREGS == 16) &&
                   ((use_rs1 && rs1_idx[4]) || (use_rs2 && rs2_idx[4]) || (use_rd && rd_idx[4]));

  logic [XW-1:0] op_b, alu_res;
  assign op_b = use_imm_q ? imm_q : b_q;

  always_comb begin
    case (kind_q)
      K_SUB:   alu_res = a_q - op_b;
      K_AND:   alu_res = a_q & op_b;
      K_OR:    alu_res = a_q | op_b;
      K_SLT:   alu_res = {{(XW-1){1'b0}}, $signed(a_q) < $signed(op_b)};
      K_LUI:   alu_res = imm_q;
`ifdef RV_BRANCH_EN
      K_JAL:   alu_res = pc_q + 32'd4;
`endif
      default: alu_res = a_q + op_b;
    endcase
  end

`ifdef RV_BRANCH_EN
  assign br_tgt   = pc_q + imm_q;
  assign br_taken = (kind_q == K_BEQ) ? (a_q == b_q) : (a_q != b_q);
`endif

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    use_imm_d = use_imm_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    r_d       = r_q;
    retire_c  = 1'b0;
    gpr_we    = 1'b0;
`ifdef RV_BRANCH_EN
    tgt_d     = tgt_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (mem_req_q && mem_ack) begin
          instr_d = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d       = gpr_q[rs1_idx[RW-1:0]];
        b_d       = gpr_q[rs2_idx[RW-1:0]];
        imm_d     = dec_imm;
        kind_d    = dec_kind;
        use_imm_d = dec_use_imm;
        state_d   = (dec_legal && !bad_idx) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        r_d = alu_res;
        if (kind_q == K_LW || kind_q == K_SW) begin
          state_d = S_MEM;
        end
`ifdef RV_BRANCH_EN
        else if (kind_q == K_BEQ || kind_q == K_BNE) begin
          if (br_taken && br_tgt[1:0] != 2'b00) begin
            state_d = S_TRAP;
          end else begin
            pc_d     = br_taken ? br_tgt : pc_q + 32'd4;
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end
        end else if (kind_q == K_JAL) begin
          tgt_d   = br_tgt;
          state_d = (br_tgt[1:0] != 2'b00) ? S_TRAP : S_WB;
        end
`endif
        else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_req_q && mem_ack) begin
          if (kind_q == K_SW) begin
            pc_d     = pc_q + 32'd4;
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end else begin
            r_d     = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        gpr_we   = (rd_idx != 5'd0);
`ifdef RV_BRANCH_EN
        pc_d     = (kind_q == K_JAL) ? tgt_q : pc_q + 32'd4;
`else
        pc_d     = pc_q + 32'd4;
`endif
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase

    // Bus outputs are registered from the next state so they are stable for the whole request
    mem_req_d   = (state_d == S_FETCH) || (state_d == S_MEM);
    mem_we_d    = (state_d == S_MEM) && (kind_q == K_SW);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_d == S_FETCH) begin
      mem_addr_d = {pc_d[31:2], 2'b00};
    end else if (state_d == S_MEM) begin
      mem_addr_d = {r_d[31:2], 2'b00};
    end
    if (mem_we_d) begin
      mem_wdata_d = b_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_FETCH;
      kind_q      <= K_ADD;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      use_imm_q   <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      r_q         <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef RV_BRANCH_EN
      tgt_q       <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      kind_q      <= kind_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      use_imm_q   <= use_imm_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      r_q         <= r_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef RV_BRANCH_EN
      tgt_q       <= tgt_d;
`endif
    end
  end

  // NOTE: the register file is built from flops and reset like any other state, so all GPRs read 0 after reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NREGS; i++) begin
        gpr_q[i] <= '0;
      end
    end else if (gpr_we) begin
      gpr_q[rd_idx[RW-1:0]] <= r_q;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign state     = state_q;
  assign retire    = retire_c;
  assign trap      = (state_q == S_TRAP);

endmodule

// File: tb/tb_rv32_mc_core.sv
// Directed bench for rv32_mc_core: word memory with programmable wait states plus an RV32E instance.
// Expected values are hand-assembled programs and hand-computed results and cycle counts.
module tb_rv32_mc_core;

  logic        clk;
  logic        rst_n;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] pc, instr;
  logic [2:0]  state;
  logic        retire, trap;

  logic        mem_req_e, mem_we_e, retire_e, trap_e;
  logic [31:0] mem_addr_e, mem_wdata_e, mem_rdata_e, pc_e, instr_e;
  logic [2:0]  state_e;

  int n_checks = 0;
  int n_fail   = 0;

  rv32_mc_core #(.RESET_PC(32'h0000_0000), .NREGS(32), .XW(32)) dut (
    .CLK(clk), .RST(rst_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pc(pc), .instr(instr), .state(state), .retire(retire), .trap(trap)
  );

  // RV32E instance: addi x15,x0,1 at 0, then addi x16,x0,1 at 4 which must trap
  rv32_mc_core #(.RESET_PC(32'h0000_0000), .NREGS(16), .XW(32)) dut_e (
    .CLK(clk), .RST(rst_n),
    .mem_req(mem_req_e), .mem_we(mem_we_e), .mem_addr(mem_addr_e), .mem_wdata(mem_wdata_e),
    .mem_ack(mem_req_e), .mem_rdata(mem_rdata_e),
    .pc(pc_e), .instr(instr_e), .state(state_e), .retire(retire_e), .trap(trap_e)
  );
  assign mem_rdata_e = mem_addr_e[2] ? 32'h0010_0813 : 32'h0010_0793;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Main memory: 64 words, ack after wait_cfg extra request cycles
  logic [31:0] mem [64];
  logic        ld_we, mem_clr;
  logic [5:0]  ld_idx;
  logic [31:0] ld_data;
  int          wait_cfg;
  int          wait_cnt = 0;

  assign mem_ack   = mem_req && (wait_cnt == wait_cfg);
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (ld_we) begin
      mem[ld_idx] <= ld_data;
    end else if (mem_req && mem_ack && mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
    wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic hold_reset(input int waits);
    rst_n    = 1'b0;
    wait_cfg = waits;
    @(negedge clk);
    mem_clr = 1'b1;
    @(negedge clk);
    mem_clr = 1'b0;
  endtask

  task automatic load(input int idx, input logic [31:0] w);
    ld_idx  = idx[5:0];
    ld_data = w;
    ld_we   = 1'b1;
    @(negedge clk);
    ld_we   = 1'b0;
  endtask

  // Counts negedges until the n-th retire pulse; cyc is the number of cycles this took
  task automatic wait_retires(input string tag, input int n, input int budget, output int cyc);
    int seen;
    seen = 0;
    cyc  = 0;
    while (seen < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (retire) seen++;
    end
    check(tag, seen, n);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
    int cyc;
    cyc = 0;
    while (state !== st && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, {29'd0, state}, {29'd0, st});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int hi;
    ld_we    = 1'b0;
    ld_idx   = '0;
    ld_data  = '0;
    mem_clr  = 1'b0;
    wait_cfg = 0;
    rst_n    = 1'b0;

    // ---- Reset state ----
    @(negedge clk);
    check("rst pc", pc, 32'h0);
    check("rst instr", instr, 32'h0);
    check("rst state", {29'd0, state}, 32'd0);
    check("rst mem_req", {31'd0, mem_req}, 32'd0);
    check("rst mem_we", {31'd0, mem_we}, 32'd0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    check("rst retire", {31'd0, retire}, 32'd0);
    check("rst trap", {31'd0, trap}, 32'd0);
    check("rst x1", dut.gpr_q[1], 32'h0);

    // ---- addi x1,x0,5 ; addi x2,x1,-7 with zero-wait memory ----
    hold_reset(0);
    load(0, 32'h0050_0093);
    load(1, 32'hFF90_8113);
    rst_n = 1'b1;
    @(negedge clk);
    check("first req", {31'd0, mem_req}, 32'd1);
    check("first addr", mem_addr, 32'h0);
    wait_retires("t1 retires", 2, 40, c);
    check("t1 cycles to 2nd retire", c, 32'd7);
    @(negedge clk);
    check("t1 x1", dut.gpr_q[1], 32'd5);
    check("t1 x2", dut.gpr_q[2], 32'hFFFF_FFFE);
    check("t1 pc", pc, 32'h8);
    check("rv32e trap", {31'd0, trap_e}, 32'd1);
    check("rv32e pc", pc_e, 32'h4);
    check("rv32e x15", dut_e.gpr_q[15], 32'd1);

    // ---- lui/sw/lw with 3 wait states per access ----
    hold_reset(3);
    load(0, 32'h1234_51B7);
    load(1, 32'h0030_2823);
    load(2, 32'h0100_2203);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2 req held in fetch wait", {31'd0, mem_req}, 32'd1);
    end
    wait_retires("t2 lui retire", 1, 40, c);
    check("t2 lui remaining cycles", c, 32'd3);
    wait_retires("t2 sw retire", 1, 40, c);
    check("t2 sw cycles", c, 32'd10);
    wait_retires("t2 lw retire", 1, 40, c);
    check("t2 lw cycles", c, 32'd11);
    @(negedge clk);
    check("t2 mem[16]", mem[4], 32'h1234_5000);
    check("t2 x4", dut.gpr_q[4], 32'h1234_5000);
    check("t2 pc", pc, 32'hC);

    // ---- x0 discard and ALU variants ----
    hold_reset(0);
    load(0, 32'h0090_0013);  // addi x0,x0,9
    load(1, 32'h0030_0293);  // addi x5,x0,3
    load(2, 32'h0000_02B3);  // add  x5,x0,x0
    load(3, 32'hFFD0_0093);  // addi x1,x0,-3
    load(4, 32'h0050_0113);  // addi x2,x0,5
    load(5, 32'h4020_81B3);  // sub  x3,x1,x2
    load(6, 32'h0020_F233);  // and  x4,x1,x2
    load(7, 32'h0020_E2B3);  // or   x5,x1,x2
    load(8, 32'h0020_A333);  // slt  x6,x1,x2
    load(9, 32'h0011_23B3);  // slt  x7,x2,x1
    load(10, 32'h0F00_F413); // andi x8,x1,0xF0
    load(11, 32'h7001_6493); // ori  x9,x2,0x700
    rst_n = 1'b1;
    wait_retires("t3 first three", 3, 60, c);
    @(negedge clk);
    check("t3 x0", dut.gpr_q[0], 32'h0);
    check("t3 x5 after add x0,x0", dut.gpr_q[5], 32'h0);
    wait_retires("t3 alu group", 9, 120, c);
    @(negedge clk);
    check("t3 sub", dut.gpr_q[3], 32'hFFFF_FFF8);
    check("t3 and", dut.gpr_q[4], 32'h0000_0005);
    check("t3 or", dut.gpr_q[5], 32'hFFFF_FFFD);
    check("t3 slt neg<pos", dut.gpr_q[6], 32'd1);
    check("t3 slt pos<neg", dut.gpr_q[7], 32'd0);
    check("t3 andi", dut.gpr_q[8], 32'h0000_00F0);
    check("t3 ori", dut.gpr_q[9], 32'h0000_0705);
    check("t3 pc", pc, 32'h30);

    // ---- Illegal word traps and freezes ----
    hold_reset(0);
    load(0, 32'h0010_0093);  // addi x1,x0,1
    load(1, 32'hFFFF_FFFF);
    rst_n = 1'b1;
    wait_retires("t4 addi retire", 1, 20, c);
    wait_state("t4 reach trap", 3'd7, 20);
    check("t4 trap", {31'd0, trap}, 32'd1);
    check("t4 instr", instr, 32'hFFFF_FFFF);
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_req || pc != 32'h4) hi++;
    end
    check("t4 idle cycles with req or pc change", hi, 32'd0);
    check("t4 pc frozen", pc, 32'h4);
    rst_n = 1'b0;
    #1;
    check("t4 pc after rst", pc, 32'h0);
    check("t4 trap after rst", {31'd0, trap}, 32'd0);
    check("t4 x1 after rst", dut.gpr_q[1], 32'h0);

    // ---- beq x0,x0,-4 at pc=8 ----
    hold_reset(0);
    load(0, 32'h0010_0093);  // addi x1,x0,1
    load(1, 32'h0020_0113);  // addi x2,x0,2
    load(2, 32'hFE00_0EE3);  // beq  x0,x0,-4
    rst_n = 1'b1;
    wait_retires("t5 prefix", 2, 40, c);
`ifdef RV_BRANCH_EN
    wait_retires("t5 beq retire", 1, 20, c);
    check("t5 beq latency", c, 32'd3);
    @(negedge clk);
    check("t5 pc after taken beq", pc, 32'h4);
    check("t5 no trap", {31'd0, trap}, 32'd0);
`else
    wait_state("t5 beq traps", 3'd7, 20);
    check("t5 trap", {31'd0, trap}, 32'd1);
    check("t5 pc frozen at beq", pc, 32'h8);
`endif

    // ---- Reset while a LW waits in MEM ----
    hold_reset(5);
    load(0, 32'h0070_0093);  // addi x1,x0,7
    load(1, 32'h0100_2203);  // lw   x4,16(x0)
    rst_n = 1'b1;
    wait_retires("t6 addi retire", 1, 40, c);
    wait_state("t6 reach mem", 3'd3, 40);
    @(negedge clk);
    check("t6 req in mem wait", {31'd0, mem_req}, 32'd1);
    check("t6 x1 before rst", dut.gpr_q[1], 32'd7);
    rst_n = 1'b0;
    #1;
    check("t6 req drops async", {31'd0, mem_req}, 32'd0);
    check("t6 x1 cleared", dut.gpr_q[1], 32'h0);
    check("t6 state", {29'd0, state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6 refetch req", {31'd0, mem_req}, 32'd1);
    check("t6 refetch addr", mem_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
